rename_unit: RTL and testbench
==============================

Name: rename_unit

Overview:
- Single-issue register rename stage directly upstream of the ROB.
- Maps architectural source/destination registers to physical registers through a speculative RAT and a circular free list.
- Produces the ROB push (dst_phys plus old mapping).
- Reclaims physical registers at commit; restores state on flush from a committed RAT and a committed free-list head.

Parameters:
- ARCH_REGS, 32, architectural register count (x0 hard-wired zero)
- PHYS_REGS, 64, physical register count
- AW, 5, architectural index width
- PW, 6, physical index width
- FL_DEPTH = PHYS_REGS-ARCH_REGS (localparam), 32, free-list entries

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  decoded instruction valid
- in_ready  out  1  rename can accept
- in_rs1, in_rs2  in  AW  source arch regs
- in_rd  in  AW  dest arch reg
- in_rd_we  in  1  instruction writes rd
- out_valid  out  1  renamed instruction valid (ROB push = out_valid & out_ready)
- out_ready  in  1  ROB can accept
- out_ps1, out_ps2  out  PW  source physical regs
- out_pd  out  PW  new dest physical reg (ROB dst_phys)
- out_old_pd  out  PW  previous mapping of rd, freed at commit
- out_rd_we  out  1  effective write (0 when rd=x0)
- commit_valid  in  1  ROB pop
- commit_rd_we  in  1  committing instruction writes rd
- commit_rd  in  AW  committed arch dest
- commit_pd  in  PW  committed physical dest
- commit_old_pd  in  PW  physical reg to free
- flush  in  1  squash all uncommitted instructions
- free_count  out  PW+1  free registers currently available

Behaviour:
- Reset (rst=0, async):
  - RAT[i]=i and cRAT[i]=i.
  - Free list holds 32..63 in order at entries 0..31.
  - head=cHead=0, tail=32 (pointers PW bits with wrap bit), free_count=32.
  - out_valid=0 and out_ps1/ps2/pd/old_pd=0, out_rd_we=0.
- Effective write: in_rd_we & (in_rd!=0). x0 never allocates; out_pd=0, out_old_pd=0, out_rd_we=0.
- in_ready = rst & ~flush & (~out_valid | out_ready) & (free_count!=0). Combinational; independent of in_* data. free_count comes from registers.
- Accept = in_valid & in_ready. On the accept edge:
  - Output register loads ps1=RAT[rs1], ps2=RAT[rs2], old_pd=RAT[rd], pd=FL[head], all read before this instruction's RAT update.
  - If effective write: RAT[rd]<=pd and head++.
- Latency: 1 cycle, in_* to out_*.
- A back-to-back dependent instruction sees the updated RAT: ps1 equals the prior pd.
- out_* held stable while out_valid & ~out_ready. out_valid clears on pop with no new accept.
- Commit (commit_valid & commit_rd_we & commit_rd!=0):
  - FL[tail]<=commit_old_pd, tail++.
  - cRAT[commit_rd]<=commit_pd, cHead++.
  - A register freed this cycle is allocatable next cycle, never the same cycle.
- free_count = tail-head (modulo 2*FL_DEPTH). Same-cycle alloc+free leaves it unchanged.
  - Invariant: tail-head <= FL_DEPTH.
  - Violating it (commit with the list full) is a protocol error; flag with an assertion only.
- Flush (highest priority over accept):
  - Commit in the same cycle is applied first.
  - RAT<=cRAT including that commit; head<=cHead including its increment.
  - out_valid<=0, no accept.
  - Speculatively allocated registers (cHead..head) return to the free list implicitly.
- Wrap-around: pointers wrap modulo FL_DEPTH on index, with the extra bit distinguishing full/empty.
- No mid-operation state survives reset; all state re-initialises asynchronously.

Test Plan:
- Reset, then idle -> free_count=32, out_valid=0, in_ready=1. Push rd=5, rs1=5 -> out_ps1=5, out_old_pd=5, out_pd=32.
- Back-to-back: add x1 (pd 32), then rs1=x1, rd=x2 -> second out_ps1=32, out_pd=33, out_old_pd=2; free_count 30.
- Exhaust: 32 accepted writes with no commit -> in_ready=0 at free_count=0. One commit freeing old_pd=7 -> in_ready=1 next cycle; next alloc gets pd=7.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_* unchanged, in_ready=0, free_count unchanged.
- Flush: rename x3->32, x4->33; commit only x3 (pd 32, free 3); flush -> RAT[x4]=4, RAT[x3]=32, head=1, free_count=32; next alloc gets pd=33.
- x0 write plus simultaneous alloc and commit -> rd=0 gives out_rd_we=0, free_count unchanged; alloc+commit same cycle keeps free_count constant, and tail wraps 63->0 correctly over 40 iterations.

Source files
------------

// File: rtl/rename_unit.sv
// rename_unit: single-issue register rename stage feeding the ROB.
//
// Sources and destinations are mapped through a speculative RAT. New
// destinations come from a circular free list. Commits return the old
// mapping to the free list and update a committed RAT and a committed
// free-list head. A flush restores both from that committed state.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   in_*              decoded instruction (valid/ready handshake)
//   out_*             renamed instruction and ROB push payload (valid/ready)
//   commit_*          ROB pop: committed dest mapping and register to free
//   flush             squash all uncommitted work
//   free_count        number of physical registers currently on the free list
module rename_unit #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int AW        = 5,
  parameter int PW        = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic [AW-1:0] in_rd,
  input  logic          in_rd_we,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_ps1,
  output logic [PW-1:0] out_ps2,
  output logic [PW-1:0] out_pd,
  output logic [PW-1:0] out_old_pd,
  output logic          out_rd_we,
  input  logic          commit_valid,
  input  logic          commit_rd_we,
  input  logic [AW-1:0] commit_rd,
  input  logic [PW-1:0] commit_pd,
  input  logic [PW-1:0] commit_old_pd,
  input  logic          flush,
  output logic [PW:0]   free_count
);

  localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int FLW      = $clog2(FL_DEPTH);
  // Free-list pointers carry one extra wrap bit so full and empty differ.
  localparam int PTRW     = FLW + 1;

  // Speculative and committed rename tables, free-list storage.
  logic [PW-1:0]   rat_q  [ARCH_REGS];
  logic [PW-1:0]   rat_d  [ARCH_REGS];
  logic [PW-1:0]   crat_q [ARCH_REGS];
  logic [PW-1:0]   crat_d [ARCH_REGS];
  logic [PW-1:0]   fl_q   [FL_DEPTH];
  logic [PW-1:0]   fl_d   [FL_DEPTH];

  logic [PTRW-1:0] head_q, head_d;
  logic [PTRW-1:0] chead_q, chead_d;
  logic [PTRW-1:0] tail_q, tail_d;

  // Output (ROB push) register.
  logic            out_valid_q, out_valid_d;
  logic [PW-1:0]   out_ps1_q, out_ps1_d;
  logic [PW-1:0]   out_ps2_q, out_ps2_d;
  logic [PW-1:0]   out_pd_q, out_pd_d;
  logic [PW-1:0]   out_old_pd_q, out_old_pd_d;
  logic            out_rd_we_q, out_rd_we_d;

  logic [PTRW-1:0] count;
  logic [FLW-1:0]  head_idx;
  logic [FLW-1:0]  tail_idx;
  logic            accept;
  logic            alloc;
  logic            commit_fire;

  assign out_valid  = out_valid_q;
  assign out_ps1    = out_ps1_q;
  assign out_ps2    = out_ps2_q;
  assign out_pd     = out_pd_q;
  assign out_old_pd = out_old_pd_q;
  assign out_rd_we  = out_rd_we_q;

  // Handshake and bookkeeping, all derived from registered state plus
  // control inputs (never from in_* payload).
  always_comb begin
    count       = tail_q - head_q;
    free_count  = (PW+1)'(count);
    head_idx    = head_q[FLW-1:0];
    tail_idx    = tail_q[FLW-1:0];
    in_ready    = rst & ~flush & (~out_valid_q | out_ready) & (count != '0);
    accept      = in_valid & in_ready;
    alloc       = accept & in_rd_we & (in_rd != '0);
    commit_fire = commit_valid & commit_rd_we & (commit_rd != '0);
  end

  // Next-state logic. Commit is evaluated first so a same-cycle flush
  // restores from committed state that already includes this commit.
  // The freed entry lands in fl_d and is only readable next cycle.
  always_comb begin
    crat_d       = crat_q;
    chead_d      = chead_q;
    fl_d         = fl_q;
    tail_d       = tail_q;
    rat_d        = rat_q;
    head_d       = head_q;
    out_valid_d  = out_valid_q;
    out_ps1_d    = out_ps1_q;
    out_ps2_d    = out_ps2_q;
    out_pd_d     = out_pd_q;
    out_old_pd_d = out_old_pd_q;
    out_rd_we_d  = out_rd_we_q;

    if (commit_fire) begin
      fl_d[tail_idx]    = commit_old_pd;
      tail_d            = tail_q + PTRW'(1);
      crat_d[commit_rd] = commit_pd;
      chead_d           = chead_q + PTRW'(1);
    end

    if (flush) begin
      // Registers allocated between chead and head return to the free
      // list simply by rewinding head; their entries are still intact.
      rat_d       = crat_d;
      head_d      = chead_d;
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_ps1_d   = rat_q[in_rs1];
      out_ps2_d   = rat_q[in_rs2];
      if (alloc) begin
        out_pd_d     = fl_q[head_idx];
        out_old_pd_d = rat_q[in_rd];
        out_rd_we_d  = 1'b1;
        rat_d[in_rd] = fl_q[head_idx];
        head_d       = head_q + PTRW'(1);
      end else begin
        out_pd_d     = '0;
        out_old_pd_d = '0;
        out_rd_we_d  = 1'b0;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) begin
        rat_q[i]  <= PW'(i);
        crat_q[i] <= PW'(i);
      end
      for (int unsigned i = 0; i < FL_DEPTH; i++) begin
        fl_q[i] <= PW'(ARCH_REGS + i);
      end
      head_q       <= '0;
      chead_q      <= '0;
      tail_q       <= PTRW'(FL_DEPTH);
      out_valid_q  <= 1'b0;
      out_ps1_q    <= '0;
      out_ps2_q    <= '0;
      out_pd_q     <= '0;
      out_old_pd_q <= '0;
      out_rd_we_q  <= 1'b0;
    end else begin
      rat_q        <= rat_d;
      crat_q       <= crat_d;
      fl_q         <= fl_d;
      head_q       <= head_d;
      chead_q      <= chead_d;
      tail_q       <= tail_d;
      out_valid_q  <= out_valid_d;
      out_ps1_q    <= out_ps1_d;
      out_ps2_q    <= out_ps2_d;
      out_pd_q     <= out_pd_d;
      out_old_pd_q <= out_old_pd_d;
      out_rd_we_q  <= out_rd_we_d;
    end
  end

  // Freeing into a full list (without a same-cycle allocation) would
  // overwrite a live entry: upstream protocol error.
  a_no_overfill : assert property (@(posedge clk) disable iff (!rst)
    !(commit_fire && !alloc && (count == PTRW'(FL_DEPTH))));

  a_count_bound : assert property (@(posedge clk) disable iff (!rst)
    count <= PTRW'(FL_DEPTH));

endmodule

// File: tb/tb_rename_unit.sv
module tb_rename_unit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_rs1, in_rs2, in_rd;
  logic       in_rd_we;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_ps1, out_ps2, out_pd, out_old_pd;
  logic       out_rd_we;
  logic       commit_valid;
  logic       commit_rd_we;
  logic [4:0] commit_rd;
  logic [5:0] commit_pd, commit_old_pd;
  logic       flush;
  logic [6:0] free_count;

  int checks;
  int errors;

  logic [5:0] fl_model [$];
  logic [5:0] prev_pd;
  logic [5:0] exp_pd;

  rename_unit #(.ARCH_REGS(32), .PHYS_REGS(64), .AW(5), .PW(6)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ps1(out_ps1), .out_ps2(out_ps2), .out_pd(out_pd),
    .out_old_pd(out_old_pd), .out_rd_we(out_rd_we),
    .commit_valid(commit_valid), .commit_rd_we(commit_rd_we),
    .commit_rd(commit_rd), .commit_pd(commit_pd), .commit_old_pd(commit_old_pd),
    .flush(flush), .free_count(free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    in_valid      = 1'b0;
    in_rs1        = '0;
    in_rs2        = '0;
    in_rd         = '0;
    in_rd_we      = 1'b0;
    out_ready     = 1'b1;
    commit_valid  = 1'b0;
    commit_rd_we  = 1'b0;
    commit_rd     = '0;
    commit_pd     = '0;
    commit_old_pd = '0;
    flush         = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
  endtask

  task automatic push(input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic we);
    in_valid = 1'b1;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_rd    = rd;
    in_rd_we = we;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset state and a first rename of x5 <- x5.
    do_reset();
    check("rst_free_count", 32'(free_count), 32);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_pd", 32'(out_pd), 0);
    check("rst_out_rd_we", 32'(out_rd_we), 0);
    push(5'd5, 5'd0, 5'd5, 1'b1);
    step();
    in_valid = 1'b0;
    check("first_valid", 32'(out_valid), 1);
    check("first_ps1", 32'(out_ps1), 5);
    check("first_old_pd", 32'(out_old_pd), 5);
    check("first_pd", 32'(out_pd), 32);
    check("first_rd_we", 32'(out_rd_we), 1);
    check("first_free_count", 32'(free_count), 31);
    step();
    check("pop_clears_valid", 32'(out_valid), 0);

    // Back-to-back dependent pair.
    do_reset();
    push(5'd0, 5'd0, 5'd1, 1'b1);
    step();
    check("b2b_pd0", 32'(out_pd), 32);
    push(5'd1, 5'd0, 5'd2, 1'b1);
    step();
    in_valid = 1'b0;
    check("b2b_ps1", 32'(out_ps1), 32);
    check("b2b_pd1", 32'(out_pd), 33);
    check("b2b_old_pd", 32'(out_old_pd), 2);
    check("b2b_free_count", 32'(free_count), 30);

    // Exhaust the free list, then free one register through commit.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      push(5'd0, 5'd0, 5'((i % 31) + 1), 1'b1);
      step();
      check("exh_pd", 32'(out_pd), 32'(32 + i));
    end
    in_valid = 1'b0;
    #1;
    check("exh_free_count", 32'(free_count), 0);
    check("exh_in_ready", 32'(in_ready), 0);
    commit_valid  = 1'b1;
    commit_rd_we  = 1'b1;
    commit_rd     = 5'd7;
    commit_pd     = 6'd38;
    commit_old_pd = 6'd7;
    #1;
    check("exh_not_same_cycle", 32'(in_ready), 0);
    step();
    commit_valid = 1'b0;
    commit_rd_we = 1'b0;
    #1;
    check("exh_fc_after_commit", 32'(free_count), 1);
    check("exh_ready_after_commit", 32'(in_ready), 1);
    push(5'd0, 5'd0, 5'd10, 1'b1);
    step();
    in_valid = 1'b0;
    check("exh_realloc_pd", 32'(out_pd), 7);
    check("exh_realloc_fc", 32'(free_count), 0);

    // Backpressure: output held while the ROB stalls.
    do_reset();
    push(5'd4, 5'd0, 5'd3, 1'b1);
    step();
    push(5'd3, 5'd0, 5'd6, 1'b1);
    out_ready = 1'b0;
    #1;
    check("bp_in_ready_low", 32'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_valid", 32'(out_valid), 1);
      check("bp_pd", 32'(out_pd), 32);
      check("bp_ps1", 32'(out_ps1), 4);
      check("bp_old_pd", 32'(out_old_pd), 3);
      check("bp_free_count", 32'(free_count), 31);
      check("bp_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    check("bp_next_pd", 32'(out_pd), 33);
    check("bp_next_ps1", 32'(out_ps1), 32);
    check("bp_next_old_pd", 32'(out_old_pd), 6);

    // Flush with a same-cycle commit of the older instruction.
    do_reset();
    push(5'd0, 5'd0, 5'd3, 1'b1);
    step();
    push(5'd0, 5'd0, 5'd4, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    check("fl_pre_fc", 32'(free_count), 30);
    commit_valid  = 1'b1;
    commit_rd_we  = 1'b1;
    commit_rd     = 5'd3;
    commit_pd     = 6'd32;
    commit_old_pd = 6'd3;
    flush         = 1'b1;
    push(5'd1, 5'd1, 5'd9, 1'b1);
    #1;
    check("fl_in_ready", 32'(in_ready), 0);
    step();
    in_valid     = 1'b0;
    commit_valid = 1'b0;
    commit_rd_we = 1'b0;
    flush        = 1'b0;
    #1;
    check("fl_out_valid", 32'(out_valid), 0);
    check("fl_free_count", 32'(free_count), 32);
    push(5'd4, 5'd3, 5'd5, 1'b1);
    step();
    in_valid = 1'b0;
    check("fl_ps1_x4", 32'(out_ps1), 4);
    check("fl_ps2_x3", 32'(out_ps2), 32);
    check("fl_pd", 32'(out_pd), 33);
    check("fl_old_pd", 32'(out_old_pd), 5);

    // x0 write, then alloc+commit every cycle across pointer wrap.
    do_reset();
    push(5'd0, 5'd0, 5'd0, 1'b1);
    step();
    check("x0_valid", 32'(out_valid), 1);
    check("x0_rd_we", 32'(out_rd_we), 0);
    check("x0_pd", 32'(out_pd), 0);
    check("x0_old_pd", 32'(out_old_pd), 0);
    check("x0_free_count", 32'(free_count), 32);
    push(5'd0, 5'd0, 5'd1, 1'b1);
    step();
    check("wrap_first_pd", 32'(out_pd), 32);
    check("wrap_first_fc", 32'(free_count), 31);
    fl_model.delete();
    for (int v = 33; v < 64; v++) fl_model.push_back(6'(v));
    prev_pd = 6'd32;
    for (int i = 0; i < 40; i++) begin
      push(5'd1, 5'd0, 5'd1, 1'b1);
      commit_valid  = 1'b1;
      commit_rd_we  = 1'b1;
      commit_rd     = 5'd1;
      commit_pd     = prev_pd;
      commit_old_pd = prev_pd;
      exp_pd = fl_model.pop_front();
      fl_model.push_back(prev_pd);
      step();
      check("wrap_pd", 32'(out_pd), 32'(exp_pd));
      check("wrap_fc", 32'(free_count), 31);
      prev_pd = exp_pd;
    end
    in_valid     = 1'b0;
    commit_valid = 1'b0;
    commit_rd_we = 1'b0;
    step();
    check("wrap_end_fc", 32'(free_count), 31);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
